// File: rtl/xyolo_read.sv
// Operand read sequencer: walks pixel/weight/bias buffers for iter outputs of per terms each.
// Optional bias path is compiled in with macro XYOLO_READ_BIAS_EN.
module xyolo_read #(
  parameter int DATAPATH_W = 32,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 16,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  input  logic [CNT_W-1:0]      iter,
  input  logic [CNT_W-1:0]      per,
  input  logic [ADDR_W-1:0]     pix_start,
  input  logic [ADDR_W-1:0]     pix_incr,
  input  logic [ADDR_W-1:0]     pix_shift,
  input  logic [ADDR_W-1:0]     wgt_start,
  input  logic [ADDR_W-1:0]     wgt_incr,
  input  logic [ADDR_W-1:0]     bias_start,
  output logic [ADDR_W-1:0]     pix_addr,
  output logic [ADDR_W-1:0]     wgt_addr,
  output logic [ADDR_W-1:0]     bias_addr,
  output logic                  pix_en,
  output logic                  wgt_en,
  output logic                  bias_en,
  input  logic [DATAPATH_W-1:0] pix_data,
  input  logic [DATAPATH_W-1:0] wgt_data,
  input  logic [DATAPATH_W-1:0] bias_data,
  output logic [DATAPATH_W-1:0] flow_out_pixel,
  output logic [DATAPATH_W-1:0] flow_out_weight,
  output logic [DATAPATH_W-1:0] flow_out_bias,
  output logic                  ld_acc,
  output logic                  ld_res,
  output logic                  ld_mp
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    iter_q, per_q, i_q, j_q, drain_q;
  logic [ADDR_W-1:0]   pix_incr_q, pix_shift_q, wgt_start_q, wgt_incr_q;
  logic [ADDR_W-1:0]   row_q, pix_addr_q, wgt_addr_q, bias_addr_q;
  logic                en_q, bias_en_q, done_q;
  logic                vld_q, bvld_q, first_q, last_q, mp_q;
  logic [MUL_LAT-1:0]  res_pipe_q, mp_pipe_q;
  logic                last_j, last_i;

`ifdef XYOLO_READ_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
  assign flow_out_bias = bvld_q ? bias_data : '0;
`else
  localparam bit BIAS_ON = 1'b0;
  logic unused_bias;
  assign unused_bias   = ^{bias_data, bvld_q};
  assign flow_out_bias = '0;
`endif

  assign last_j = (j_q == per_q - 1'b1);
  assign last_i = (i_q == iter_q - 1'b1);

  assign done      = done_q;
  assign pix_addr  = pix_addr_q;
  assign wgt_addr  = wgt_addr_q;
  assign bias_addr = bias_addr_q;
  assign pix_en    = en_q;
  assign wgt_en    = en_q;
  assign bias_en   = bias_en_q;

  // Buffer data arrives one cycle after issue; forward it straight to the datapath.
  assign flow_out_pixel  = vld_q ? pix_data : '0;
  assign flow_out_weight = vld_q ? wgt_data : '0;
  assign ld_acc          = first_q;
  assign ld_res          = res_pipe_q[MUL_LAT-1];
  assign ld_mp           = mp_pipe_q[MUL_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b1;
      iter_q      <= '0;
      per_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      drain_q     <= '0;
      pix_incr_q  <= '0;
      pix_shift_q <= '0;
      wgt_start_q <= '0;
      wgt_incr_q  <= '0;
      row_q       <= '0;
      pix_addr_q  <= '0;
      wgt_addr_q  <= '0;
      bias_addr_q <= '0;
      en_q        <= 1'b0;
      bias_en_q   <= 1'b0;
      vld_q       <= 1'b0;
      bvld_q      <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      mp_q        <= 1'b0;
      res_pipe_q  <= '0;
      mp_pipe_q   <= '0;
    end else begin
      // Operand-return stage, then the multiplier-latency delay line for result strobes.
      vld_q         <= en_q;
      bvld_q        <= bias_en_q;
      first_q       <= en_q && (j_q == '0);
      last_q        <= en_q && last_j;
      mp_q          <= en_q && last_j && (i_q != '0);
      res_pipe_q[0] <= last_q;
      mp_pipe_q[0]  <= mp_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        res_pipe_q[k] <= res_pipe_q[k-1];
        mp_pipe_q[k]  <= mp_pipe_q[k-1];
      end

      case (state_q)
        IDLE: begin
          if (run && (iter != '0) && (per != '0)) begin
            state_q     <= READ;
            done_q      <= 1'b0;
            iter_q      <= iter;
            per_q       <= per;
            pix_incr_q  <= pix_incr;
            pix_shift_q <= pix_shift;
            wgt_start_q <= wgt_start;
            wgt_incr_q  <= wgt_incr;
            i_q         <= '0;
            j_q         <= '0;
            row_q       <= pix_start;
            pix_addr_q  <= pix_start;
            wgt_addr_q  <= wgt_start;
            bias_addr_q <= BIAS_ON ? bias_start : '0;
            en_q        <= 1'b1;
            bias_en_q   <= BIAS_ON;
          end
        end
        READ: begin
          if (last_j) begin
            if (last_i) begin
              state_q   <= DRAIN;
              drain_q   <= '0;
              en_q      <= 1'b0;
              bias_en_q <= 1'b0;
            end else begin
              // Next output row: pixel base advances by the outer stride, weights rewind.
              i_q        <= i_q + 1'b1;
              j_q        <= '0;
              row_q      <= row_q + pix_shift_q;
              pix_addr_q <= row_q + pix_shift_q;
              wgt_addr_q <= wgt_start_q;
              bias_en_q  <= BIAS_ON;
            end
          end else begin
            j_q        <= j_q + 1'b1;
            pix_addr_q <= pix_addr_q + pix_incr_q;
            wgt_addr_q <= wgt_addr_q + wgt_incr_q;
            bias_en_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_q == CNT_W'(MUL_LAT)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xyolo_read.sv
// Directed bench for xyolo_read: per-cycle expected trace queued at each run and compared cycle by cycle.
module tb_xyolo_read;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int ML = 4;
`ifdef XYOLO_READ_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  typedef struct packed {
    logic          en;
    logic [AW-1:0] pa;
    logic [AW-1:0] wa;
    logic          ben;
    logic [DW-1:0] fp;
    logic [DW-1:0] fw;
    logic [DW-1:0] fb;
    logic          acc;
    logic          res;
    logic          mp;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [CW-1:0] iter = '0, per = '0;
  logic [AW-1:0] pix_start = '0, pix_incr = '0, pix_shift = '0;
  logic [AW-1:0] wgt_start = '0, wgt_incr = '0, bias_start = '0;
  logic [DW-1:0] pix_data = '0, wgt_data = '0;
  logic [DW-1:0] bias_data = 32'd7;
  logic done, pix_en, wgt_en, bias_en, ld_acc, ld_res, ld_mp;
  logic [AW-1:0] pix_addr, wgt_addr, bias_addr;
  logic [DW-1:0] flow_out_pixel, flow_out_weight, flow_out_bias;

  int ncmp = 0;
  int nerr = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Buffer model: one-cycle read latency, data equals address.
  always @(posedge clk) begin
    if (pix_en) pix_data <= DW'(pix_addr);
    if (wgt_en) wgt_data <= DW'(wgt_addr);
  end

  xyolo_read #(.DATAPATH_W(DW), .ADDR_W(AW), .CNT_W(CW), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .iter(iter), .per(per),
    .pix_start(pix_start), .pix_incr(pix_incr), .pix_shift(pix_shift),
    .wgt_start(wgt_start), .wgt_incr(wgt_incr), .bias_start(bias_start),
    .pix_addr(pix_addr), .wgt_addr(wgt_addr), .bias_addr(bias_addr),
    .pix_en(pix_en), .wgt_en(wgt_en), .bias_en(bias_en),
    .pix_data(pix_data), .wgt_data(wgt_data), .bias_data(bias_data),
    .flow_out_pixel(flow_out_pixel), .flow_out_weight(flow_out_weight),
    .flow_out_bias(flow_out_bias), .ld_acc(ld_acc), .ld_res(ld_res), .ld_mp(ld_mp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_cycle(input exp_t e, input string name, input int t);
    string p;
    p = $sformatf("%s/c%0d", name, t);
    chk({p, "/done"},    64'(done),            64'(e.done));
    chk({p, "/pix_en"},  64'(pix_en),          64'(e.en));
    chk({p, "/wgt_en"},  64'(wgt_en),          64'(e.en));
    chk({p, "/bias_en"}, 64'(bias_en),         64'(e.ben));
    chk({p, "/ld_acc"},  64'(ld_acc),          64'(e.acc));
    chk({p, "/ld_res"},  64'(ld_res),          64'(e.res));
    chk({p, "/ld_mp"},   64'(ld_mp),           64'(e.mp));
    chk({p, "/fpix"},    64'(flow_out_pixel),  64'(e.fp));
    chk({p, "/fwgt"},    64'(flow_out_weight), 64'(e.fw));
    chk({p, "/fbias"},   64'(flow_out_bias),   64'(e.fb));
    if (e.en) begin
      chk({p, "/pix_addr"}, 64'(pix_addr), 64'(e.pa));
      chk({p, "/wgt_addr"}, 64'(wgt_addr), 64'(e.wa));
    end
    if (!BIAS) chk({p, "/bias_addr"}, 64'(bias_addr), 64'd0);
  endtask

  task automatic do_run(input string name, input int it, input int pe, input int ps, input int pi,
                        input int psh, input int ws, input int wi, input int glitch);
    int   n;
    int   tt;
    int   i;
    int   j;
    exp_t e[];
    exp_t x;
    n  = it * pe;
    tt = n + ML + 4;
    e  = new[tt + ML + 4];
    for (int t = 0; t < tt + ML + 4; t++) begin
      e[t] = '0;
      e[t].done = (n == 0) || (t > n + 1 + ML);
    end
    for (int k = 0; k < n; k++) begin
      i = k / pe;
      j = k % pe;
      e[k+1].en  = 1'b1;
      e[k+1].pa  = AW'(ps + i * psh + j * pi);
      e[k+1].wa  = AW'(ws + j * wi);
      e[k+1].ben = BIAS && (j == 0);
      e[k+2].fp  = DW'(e[k+1].pa);
      e[k+2].fw  = DW'(e[k+1].wa);
      e[k+2].fb  = (BIAS && (j == 0)) ? 32'd7 : 32'd0;
      e[k+2].acc = (j == 0);
      if (j == pe - 1) begin
        e[k+2+ML].res = 1'b1;
        e[k+2+ML].mp  = (i != 0);
      end
    end
    for (int t = 1; t <= tt; t++) sb.push_back(e[t]);

    iter = CW'(it); per = CW'(pe);
    pix_start = AW'(ps); pix_incr = AW'(pi); pix_shift = AW'(psh);
    wgt_start = AW'(ws); wgt_incr = AW'(wi); bias_start = AW'(33);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    // Scramble configuration inputs: the DUT must hold what it latched.
    iter = CW'(9); per = CW'(7); pix_start = AW'(77); pix_incr = AW'(13);
    pix_shift = AW'(200); wgt_start = AW'(500); wgt_incr = AW'(31);
    for (int t = 1; t <= tt; t++) begin
      run = (t == glitch);
      @(negedge clk);
      x = sb.pop_front();
      check_cycle(x, name, t);
      @(posedge clk); #1;
    end
    run = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    z.done = 1'b1;

    @(negedge clk);
    check_cycle(z, "reset", 0);
    chk("reset/pix_addr", 64'(pix_addr), 64'd0);
    chk("reset/wgt_addr", 64'(wgt_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_run("basic",    1, 4, 0, 1, 0, 8, 1, 0);
    do_run("stride",   3, 2, 0, 1, 5, 0, 1, 0);
    do_run("pixwrap",  2, 4, 1022, 1, 1, 0, 1, 0);
    do_run("wgtwrap",  1, 3, 4, 2, 0, 1020, 3, 0);
    do_run("per1",     3, 1, 10, 1, 3, 20, 1, 0);
    do_run("per0",     3, 0, 5, 1, 1, 5, 1, 0);
    do_run("iter0",    0, 3, 5, 1, 1, 5, 1, 0);
    do_run("glitch",   2, 3, 100, 2, 10, 40, 4, 2);

    // Reset in the middle of a READ sequence.
    iter = CW'(3); per = CW'(3); pix_start = AW'(50); pix_incr = AW'(1);
    pix_shift = AW'(8); wgt_start = AW'(60); wgt_incr = AW'(1);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_cycle(z, "midrst", 0);
    chk("midrst/pix_addr", 64'(pix_addr), 64'd0);
    chk("midrst/wgt_addr", 64'(wgt_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 1; t <= ML + 4; t++) begin
      @(negedge clk);
      check_cycle(z, "postrst", t);
      @(posedge clk); #1;
    end

    do_run("restart",  2, 2, 3, 1, 4, 7, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/xyolo_read.md
XYOLO_READ -- requirements
Module: xyolo_read

Interface
REQ-001 The block SHALL have parameter DATAPATH_W, default 32, operand width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, buffer address width.
REQ-003 The block SHALL have parameter CNT_W, default 16, loop counter width.
REQ-004 The block SHALL have parameter MUL_LAT, default 4, downstream multiplier latency in cycles.
REQ-005 The block SHALL have ports as follows:
  clk  in  1  clock
  rst  in  1  reset, asynchronous, active-high
  run  in  1  start pulse; configuration sampled this cycle
  done  out  1  high while idle
  iter  in  CNT_W  number of outputs
  per  in  CNT_W  accumulation length per output
  pix_start, pix_incr, pix_shift  in  ADDR_W each  pixel base, inner stride, outer stride
  wgt_start, wgt_incr  in  ADDR_W each  weight base, inner stride
  bias_start  in  ADDR_W  bias address
  pix_addr/wgt_addr/bias_addr  out  ADDR_W each  buffer read addresses
  pix_en/wgt_en/bias_en  out  1 each  buffer read enables
  pix_data/wgt_data/bias_data  in  DATAPATH_W each  read data, 1-cycle read latency
  flow_out_pixel, flow_out_weight, flow_out_bias  out  DATAPATH_W each  operand stream to datapath
  ld_acc  out  1  first operand of an accumulation group
  ld_res  out  1  accumulated result ready for capture
  ld_mp  out  1  result capture is a subsequent maxpool candidate

Function
REQ-006 FSM states SHALL be IDLE, READ, DRAIN; IDLE->READ on run when iter!=0 and per!=0; READ->DRAIN after last (i,j) address issued; DRAIN->IDLE after MUL_LAT+1 cycles.
REQ-007 run with iter==0 or per==0 SHALL issue no reads and keep done high.
REQ-008 run while not IDLE SHALL be ignored; configuration is latched only on accepted run.
REQ-009 In READ, one address set SHALL be issued per cycle, j inner (0..per-1), i outer (0..iter-1).
REQ-010 pix_addr SHALL equal pix_start + i*pix_shift + j*pix_incr, computed by running accumulators, modulo 2^ADDR_W.
REQ-011 wgt_addr SHALL equal wgt_start + j*wgt_incr modulo 2^ADDR_W, restarting each i.
REQ-012 bias_addr SHALL equal bias_start; bias_en SHALL pulse only on j==0.
REQ-013 pix_en and wgt_en SHALL be high exactly on issue cycles.
REQ-014 flow_out_pixel/weight/bias SHALL be the buffer data returned one cycle after issue, combinationally forwarded; zero when no valid data.
REQ-015 ld_acc SHALL be high in the cycle the j==0 operands appear on flow_out_*.
REQ-016 ld_res SHALL pulse MUL_LAT cycles after the j==per-1 operands appear, once per output i.
REQ-017 ld_mp SHALL accompany ld_res for every i except i==0.
REQ-018 done SHALL fall the cycle after an accepted run and rise the cycle after the final ld_res.
REQ-019 per==1 SHALL assert ld_acc on every operand and produce iter ld_res pulses spaced one cycle apart.

Reset
REQ-020 rst SHALL force IDLE, done=1, all counters, enables, addresses, ld_* and flow_out_* to 0, including mid-operation; no pending ld_res survives reset.

Configuration
REQ-021 Macro XYOLO_READ_BIAS_EN: when defined, bias port, bias_en and flow_out_bias operate per REQ-012/014; when undefined, bias_en=0, bias_addr=0, flow_out_bias=0 constant, bias_data ignored.

Verification
REQ-022 iter=1, per=4, pix 0/1, wgt 8/1, data=address -> pixel 0,1,2,3, weight 8,9,10,11, ld_acc on first, ld_res 4 cycles after last.
REQ-023 iter=3, per=2, pix_shift=5, pix_incr=1 -> pix_addr 0,1,5,6,10,11; wgt_addr 0,1,0,1,0,1; ld_mp on 2nd and 3rd ld_res only.
REQ-024 pix_start=1022, pix_incr=1, per=4 -> pix_addr 1022,1023,0,1.
REQ-025 run with per=0 -> no enables, done stays 1; run pulsed during READ -> ignored, sequence unchanged.
REQ-026 rst asserted mid-READ -> next cycle all outputs 0, done=1, no ld_res afterwards; new run restarts from i=0,j=0.
REQ-027 Bias macro undefined, bias_data=7 -> flow_out_bias=0 and bias_en=0 throughout.
